mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage in-order pipeline.
// Holds one EX bundle, waits for the data-SRAM response on loads, aligns and
// extends load data, and hands {dest, final_result, gr_we} to WB under a
// valid/allow-in handshake. Also drives a forwarding/stall bus back to ID.
//
// Ports:
//   clk                pipeline clock
//   reset              synchronous, active-high reset
//   to_MEM_data        {pc, alu_result, dest, gr_we, res_from_mem, ld_type, addr_lo}
//   EX_to_MEM_valid    EX holds a valid bundle
//   MEM_allow_in       MEM can accept a bundle this cycle
//   data_sram_data_ok  one-cycle pulse: load data returned
//   data_sram_rdata    load data, valid with data_ok
//   to_WB_data         {27'b0, dest, final_result, gr_we}
//   MEM_to_WB_valid    bundle valid and ready to go
//   WB_allow_in        WB can accept
//   MEM_fwd            {fwd_we, load_pending, dest, result} to ID
module mem_stage #(
  parameter int unsigned EX_W = 76,
  parameter int unsigned WB_W = 65
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [EX_W-1:0] to_MEM_data,
  input  logic            EX_to_MEM_valid,
  output logic            MEM_allow_in,
  input  logic            data_sram_data_ok,
  input  logic [31:0]     data_sram_rdata,
  output logic [WB_W-1:0] to_WB_data,
  output logic            MEM_to_WB_valid,
  input  logic            WB_allow_in,
  output logic [38:0]     MEM_fwd
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic        mem_valid_q;
  logic [43:0] mem_data_q;   // pc is not needed past EX, so only the low fields are kept
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        unused_pc;
  assign unused_pc = ^to_MEM_data[EX_W-1:44];

  logic [31:0] alu_result;
  logic [4:0]  dest;
  logic        gr_we;
  logic        res_from_mem;
  logic [2:0]  ld_type;
  logic [1:0]  addr_lo;

  assign alu_result   = mem_data_q[43:12];
  assign dest         = mem_data_q[11:7];
  assign gr_we        = mem_data_q[6];
  assign res_from_mem = mem_data_q[5];
  assign ld_type      = mem_data_q[4:2];
  assign addr_lo      = mem_data_q[1:0];

  logic buf_valid;
  logic mem_ready_go;
  logic load_pending;
  logic fwd_we;

  assign buf_valid       = (state_q == StHold);
  assign mem_ready_go    = ~res_from_mem | buf_valid | data_sram_data_ok;
  assign MEM_allow_in    = ~mem_valid_q | (mem_ready_go & WB_allow_in);
  assign MEM_to_WB_valid = mem_valid_q & mem_ready_go;
  assign load_pending    = mem_valid_q & res_from_mem & ~mem_ready_go;
  assign fwd_we          = mem_valid_q & gr_we & (dest != 5'd0);

  // Load response tracking. Only a resident load advances the FSM, so a stray
  // data_ok with no load (or a second one while buffered) is ignored.
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    if (mem_valid_q && res_from_mem) begin
      unique case (state_q)
        StIdle, StWait: begin
          if (data_sram_data_ok) begin
            if (WB_allow_in) begin
              state_d = StIdle;
            end else begin
              state_d     = StHold;
              rdata_buf_d = data_sram_rdata;
            end
          end else begin
            state_d = StWait;
          end
        end
        StHold: begin
          if (WB_allow_in) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      state_q     <= StIdle;
    end else begin
      state_q <= state_d;
      if (MEM_allow_in) mem_valid_q <= EX_to_MEM_valid;
    end
  end

  // Payload registers carry no reset; everything they drive is gated by mem_valid_q.
  always_ff @(posedge clk) begin
    rdata_buf_q <= rdata_buf_d;
    if (MEM_allow_in && EX_to_MEM_valid) mem_data_q <= to_MEM_data[43:0];
  end

  logic [31:0] raw_data;
  logic [31:0] shifted;
  logic [31:0] ld_ext;
  logic [31:0] final_result;

  assign raw_data = buf_valid ? rdata_buf_q : data_sram_rdata;
  assign shifted  = raw_data >> {addr_lo, 3'b000};

  always_comb begin
    ld_ext = shifted;
    case (ld_type)
      3'b001:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b010:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_ext = {24'd0, shifted[7:0]};
      3'b110:  ld_ext = {16'd0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  assign final_result = res_from_mem ? ld_ext : alu_result;

  assign to_WB_data = mem_valid_q ? {{(WB_W-38){1'b0}}, dest, final_result, gr_we} : '0;
  assign MEM_fwd    = {fwd_we, load_pending,
                       mem_valid_q ? dest : 5'd0,
                       mem_valid_q ? final_result : 32'd0};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic,
// all compared against a single-slot behavioural model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [75:0] to_MEM_data;
  logic        EX_to_MEM_valid;
  logic        MEM_allow_in;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [64:0] to_WB_data;
  logic        MEM_to_WB_valid;
  logic        WB_allow_in;
  logic [38:0] MEM_fwd;

  mem_stage #(.EX_W(76), .WB_W(65)) dut (
    .clk               (clk),
    .reset             (reset),
    .to_MEM_data       (to_MEM_data),
    .EX_to_MEM_valid   (EX_to_MEM_valid),
    .MEM_allow_in      (MEM_allow_in),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .to_WB_data        (to_WB_data),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .WB_allow_in       (WB_allow_in),
    .MEM_fwd           (MEM_fwd)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: one slot, plus "data already captured" for a load.
  logic        m_valid;
  logic [75:0] m_b;
  logic        m_have;
  logic [31:0] m_data;
  logic        m_allow;  // model's allow-in for the cycle just stepped

  // Observations from the last stepped cycle.
  logic        last_allow, last_wbv;
  logic [38:0] last_fwd;
  logic [64:0] wb_log[$];
  int unsigned pend_cnt;

  function automatic logic [75:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                     input logic [4:0] d, input logic we, input logic ld,
                                     input logic [2:0] lt, input logic [1:0] al);
    return {pc, alu, d, we, ld, lt, al};
  endfunction

  // Load extension from plain arithmetic on byte/halfword values.
  function automatic logic [31:0] ext_ref(input logic [2:0] lt, input logic [1:0] al,
                                          input logic [31:0] raw);
    int unsigned v;
    v = raw >> (8 * al);
    case (lt)
      3'd1: begin v = v % 256;   return (v >= 128)   ? v - 256   : v; end
      3'd2: begin v = v % 65536; return (v >= 32768) ? v - 65536 : v; end
      3'd5: return v % 256;
      3'd6: return v % 65536;
      default: return raw;
    endcase
  endfunction

  task automatic step(input logic exv, input logic [75:0] bun, input logic dok,
                      input logic [31:0] rd, input logic wba, input logic rst);
    logic        is_ld, ready, e_wbv, e_pend, e_fwe;
    logic [4:0]  d;
    logic [31:0] res;
    reset             = rst;
    EX_to_MEM_valid   = exv;
    to_MEM_data       = bun;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    WB_allow_in       = wba;
    @(negedge clk);
    is_ld   = m_b[5];
    d       = m_b[11:7];
    ready   = !is_ld || m_have || dok;
    res     = is_ld ? ext_ref(m_b[4:2], m_b[1:0], m_have ? m_data : rd) : m_b[43:12];
    e_wbv   = m_valid && ready;
    m_allow = !m_valid || (ready && wba);
    e_pend  = m_valid && is_ld && !ready;
    e_fwe   = m_valid && m_b[6] && (d != 5'd0);
    check_eq("allow_in", MEM_allow_in, m_allow);
    check_eq("wb_valid", MEM_to_WB_valid, e_wbv);
    check_eq("fwd_ctl", MEM_fwd[38:37], {e_fwe, e_pend});
    if (!m_valid) check_eq("fwd_idle", MEM_fwd, 39'd0);
    else begin
      check_eq("fwd_dest", MEM_fwd[36:32], d);
      if (!e_pend) check_eq("fwd_result", MEM_fwd[31:0], res);
    end
    if (e_wbv) check_eq("wb_data", to_WB_data, {27'd0, d, res, m_b[6]});
    last_allow = MEM_allow_in;
    last_wbv   = MEM_to_WB_valid;
    last_fwd   = MEM_fwd;
    if (MEM_to_WB_valid && wba) wb_log.push_back(to_WB_data);
    if (MEM_fwd[37]) pend_cnt++;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_have  = 1'b0;
    end else begin
      if (m_valid && is_ld && !m_have && dok && !wba) begin
        m_have = 1'b1;
        m_data = rd;
      end
      if (m_allow) begin
        m_valid = exv;
        m_have  = 1'b0;
        if (exv) m_b = bun;
      end
    end
    #1;
  endtask

  task automatic idle(input logic wba);
    step(1'b0, 76'd0, 1'b0, 32'd0, wba, 1'b0);
  endtask

  function automatic logic [64:0] log_first();
    return (wb_log.size() > 0) ? wb_log[0] : '1;
  endfunction

  task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] al,
                         input logic [31:0] rd, input logic [31:0] exp);
    wb_log.delete();
    step(1'b1, mk(32'h1c000100, 32'h0000_1000 | al, 5'd9, 1'b1, 1'b1, lt, al),
         1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 76'd0, 1'b1, rd, 1'b1, 1'b0);
    idle(1'b1);
    check_eq({tag, "_cnt"}, wb_log.size(), 1);
    check_eq(tag, log_first()[32:1], exp);
  endtask

  function automatic logic [75:0] rand_bundle();
    logic [2:0] lts[7] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd3, 3'd7};
    logic [2:0] lt;
    logic [1:0] al;
    lt = lts[$urandom_range(0, 6)];
    case (lt)
      3'd1, 3'd5: al = 2'($urandom_range(0, 3));
      3'd2, 3'd6: al = 2'($urandom_range(0, 1) * 2);
      default:    al = 2'd0;
    endcase
    return mk($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), lt, al);
  endfunction

  initial begin
    logic        exv, dok, wba, keep;
    logic [75:0] bun;
    reset = 1'b1;
    EX_to_MEM_valid = 1'b0;
    to_MEM_data = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    WB_allow_in = 1'b1;
    m_valid = 1'b0; m_have = 1'b0; m_b = '0; m_data = '0; m_allow = 1'b1;
    pend_cnt = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle(1'b1);
    check_eq("rst_allow", last_allow, 1'b1);
    check_eq("rst_wbv", last_wbv, 1'b0);
    check_eq("rst_fwd", last_fwd, 39'd0);

    // Back-to-back ALU ops
    wb_log.delete();
    step(1'b1, mk(32'h1c000000, 32'd1, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0), 1'b0, 0, 1'b1, 1'b0);
    step(1'b1, mk(32'h1c000004, 32'd2, 5'd6, 1'b1, 1'b0, 3'd0, 2'd0), 1'b0, 0, 1'b1, 1'b0);
    step(1'b1, mk(32'h1c000008, 32'd3, 5'd7, 1'b1, 1'b0, 3'd0, 2'd0), 1'b0, 0, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("alu_cnt", wb_log.size(), 3);
    for (int i = 0; i < 3 && i < wb_log.size(); i++) check_eq("alu_res", wb_log[i][32:1], i + 1);

    // LD.W with 3 wait cycles
    wb_log.delete();
    pend_cnt = 0;
    step(1'b1, mk(32'h1c00000c, 32'h0000_2000, 5'd8, 1'b1, 1'b1, 3'd0, 2'd0), 1'b0, 0, 1'b1,
         1'b0);
    repeat (3) step(1'b0, 76'd0, 1'b0, 32'h5555_5555, 1'b1, 1'b0);
    step(1'b0, 76'd0, 1'b1, 32'h8899AABB, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("ldw_pend", pend_cnt, 3);
    check_eq("ldw_cnt", wb_log.size(), 1);
    check_eq("ldw_res", log_first()[32:1], 32'h8899AABB);

    // Sub-word loads
    do_load("ldb",  3'd1, 2'd3, 32'h80112233, 32'hFFFFFF80);
    do_load("ldbu", 3'd5, 2'd3, 32'h80112233, 32'h00000080);
    do_load("ldh",  3'd2, 2'd2, 32'h7FFF0000, 32'h00007FFF);
    do_load("ldhu", 3'd6, 2'd2, 32'h80000000, 32'h00008000);

    // Data returns while WB is blocked: buffered copy must be delivered
    wb_log.delete();
    step(1'b1, mk(32'h1c000200, 32'h0000_3000, 5'd4, 1'b1, 1'b1, 3'd0, 2'd0), 1'b0, 0, 1'b0,
         1'b0);
    step(1'b0, 76'd0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    check_eq("hold_allow0", last_allow, 1'b0);
    step(1'b0, 76'd0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    check_eq("hold_allow1", last_allow, 1'b0);
    step(1'b0, 76'd0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("hold_cnt", wb_log.size(), 1);
    check_eq("hold_res", log_first()[32:1], 32'hCAFEF00D);

    // dest=0 never forwards but gr_we still passes to WB
    wb_log.delete();
    step(1'b1, mk(32'h1c000300, 32'd55, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0), 1'b0, 0, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("r0_fwd_we", last_fwd[38], 1'b0);
    check_eq("r0_wb_we", log_first()[0], 1'b1);

    // Reset while waiting for load data
    step(1'b1, mk(32'h1c000400, 32'h0000_4000, 5'd3, 1'b1, 1'b1, 3'd0, 2'd0), 1'b0, 0, 1'b1,
         1'b0);
    idle(1'b1);
    step(1'b0, 76'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    idle(1'b1);
    check_eq("rstw_wbv", last_wbv, 1'b0);
    check_eq("rstw_fwd", last_fwd, 39'd0);
    check_eq("rstw_allow", last_allow, 1'b1);
    wb_log.delete();
    step(1'b1, mk(32'h1c000500, 32'd77, 5'd3, 1'b1, 1'b0, 3'd0, 2'd0), 1'b0, 0, 1'b1, 1'b0);
    idle(1'b1);
    check_eq("rstw_alu_cnt", wb_log.size(), 1);
    check_eq("rstw_alu_res", log_first()[32:1], 32'd77);

    // Randomized traffic; EX holds a bundle until it is accepted
    keep = 1'b0;
    exv  = 1'b0;
    bun  = '0;
    for (int c = 0; c < 600; c++) begin
      if (!keep) begin
        exv = ($urandom_range(0, 3) != 0);
        bun = rand_bundle();
      end
      wba = ($urandom_range(0, 3) != 0);
      if (m_valid && m_b[5] && !m_have) dok = ($urandom_range(0, 2) == 0);
      else if (!m_valid || !m_b[5])     dok = ($urandom_range(0, 7) == 0);
      else                              dok = 1'b0;
      step(exv, bun, dok, $urandom, wba, 1'b0);
      keep = exv && !m_allow;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
